// File: rtl/llk_pkg.sv
// rtl/llk_pkg.sv - shared constants and FSM encoding for the card-match game
package llk_pkg;

    localparam int N_CARDS = 36;
    localparam int IDX_W   = 6;
    localparam int TYPE_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ONE    = 3'd1,
        ST_HOLD   = 3'd2,
        ST_RESULT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - one-hot to binary index, valid only when exactly one bit is set
module onehot_enc #(
    parameter int N = llk_pkg::N_CARDS,
    parameter int W = llk_pkg::IDX_W
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         valid
);

    logic seen;
    logic multi;

    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
                idx   = idx | W'(i);
            end
        end
        valid = seen & ~multi;
    end

endmodule

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - pick/hold/compare sequencer with pair score; MATCH_CTRL_TIMEOUT_EN adds a first-pick timeout
module match_ctrl #(
    parameter int N_CARDS        = llk_pkg::N_CARDS,
    parameter int TYPE_W         = llk_pkg::TYPE_W,
    parameter int HOLD_CYCLES    = 25000000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s,
    input  logic [N_CARDS-1:0]          cur_bus,
    input  logic [N_CARDS-1:0]          hidden_bus,
    input  logic [N_CARDS*TYPE_W-1:0]   type_bus,
    output logic                        ms,
    output logic                        mf,
    output logic [llk_pkg::IDX_W-1:0]   first_idx,
    output logic                        first_vld,
    output logic                        busy,
    output logic [4:0]                  pair_count,
    output logic                        done
);

    import llk_pkg::*;

    localparam int         HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [4:0] PAIRS  = 5'(N_CARDS / 2);

    if ((N_CARDS % 2) != 0 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("match_ctrl: illegal parameter value");
    end

    state_t              state;
    logic                s_q;
    logic [IDX_W-1:0]    idx2;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [IDX_W-1:0]    enc_idx;
    logic                enc_valid;
    logic                s_edge;
    logic                pick;
    logic [TYPE_W-1:0]   type1;
    logic [TYPE_W-1:0]   type2;

`ifdef MATCH_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    onehot_enc #(.N(N_CARDS), .W(IDX_W)) u_enc (
        .onehot (cur_bus),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    assign s_edge = s & ~s_q;
    assign pick   = s_edge & enc_valid & ~hidden_bus[enc_idx];
    assign type1  = type_bus[first_idx*TYPE_W +: TYPE_W];
    assign type2  = type_bus[idx2*TYPE_W +: TYPE_W];

    // Verdict is registered on the HOLD->RESULT edge so the pulse occupies the RESULT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            s_q        <= 1'b0;
            idx2       <= '0;
            hold_cnt   <= '0;
            ms         <= 1'b0;
            mf         <= 1'b0;
            first_idx  <= '0;
            first_vld  <= 1'b0;
            busy       <= 1'b0;
            pair_count <= '0;
            done       <= 1'b0;
`ifdef MATCH_CTRL_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            s_q <= s;
            ms  <= 1'b0;
            mf  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick) begin
                        first_idx <= enc_idx;
                        first_vld <= 1'b1;
                        state     <= ST_ONE;
`ifdef MATCH_CTRL_TIMEOUT_EN
                        to_cnt    <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
                ST_ONE: begin
                    if (pick) begin
                        if (enc_idx == first_idx) begin
                            mf        <= 1'b1;
                            first_vld <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            idx2     <= enc_idx;
                            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
                            busy     <= 1'b1;
                            state    <= ST_HOLD;
                        end
                    end
`ifdef MATCH_CTRL_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        mf        <= 1'b1;
                        first_vld <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_RESULT;
                        if (type1 == type2) begin
                            ms <= 1'b1;
                            if (pair_count != PAIRS) begin
                                pair_count <= pair_count + 5'd1;
                            end
                        end else begin
                            mf <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_RESULT: begin
                    busy      <= 1'b0;
                    first_vld <= 1'b0;
                    if (pair_count == PAIRS) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - directed self-checking bench for match_ctrl
module tb_match_ctrl;

    localparam int N  = 36;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s = 1'b0;
    logic [N-1:0]  cur_bus = '0;
    logic [N-1:0]  hidden_bus = '0;
    logic [N*TW-1:0] type_bus = '0;
    logic          ms, mf, first_vld, busy, done;
    logic [5:0]    first_idx;
    logic [4:0]    pair_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] ms_m, mf_m, busy_m;

    match_ctrl #(.N_CARDS(N), .TYPE_W(TW), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (s),
        .cur_bus    (cur_bus),
        .hidden_bus (hidden_bus),
        .type_bus   (type_bus),
        .ms         (ms),
        .mf         (mf),
        .first_idx  (first_idx),
        .first_vld  (first_vld),
        .busy       (busy),
        .pair_count (pair_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        s = 1'b0;
        cur_bus = '0;
        hidden_bus = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic default_types();
        type_bus = '0;
        type_bus[3*TW +: TW]  = 4'd5;
        type_bus[17*TW +: TW] = 4'd5;
        type_bus[8*TW +: TW]  = 4'd2;
    endtask

    // Drives one s edge with the given cursor; returns at the negedge of cycle E+1.
    task automatic press(input logic [N-1:0] cur);
        @(negedge clk);
        cur_bus = cur;
        s = 1'b1;
        @(negedge clk);
        s = 1'b0;
    endtask

    task automatic pick(input int card);
        logic [N-1:0] c;
        c = '0;
        c[card] = 1'b1;
        press(c);
    endtask

    // Samples cycles E2+1..E2+7; optionally raises s on card 8 at cycle poke_lo, drops it at poke_hi.
    task automatic watch(input int poke_lo, input int poke_hi,
                         output logic [7:0] ms_o, output logic [7:0] mf_o, output logic [7:0] busy_o);
        ms_o = '0;
        mf_o = '0;
        busy_o = '0;
        for (int k = 1; k <= 7; k++) begin
            ms_o[k]   = ms;
            mf_o[k]   = mf;
            busy_o[k] = busy;
            if (k == poke_lo) begin
                cur_bus = '0;
                cur_bus[8] = 1'b1;
                s = 1'b1;
            end
            if (k == poke_hi) s = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [N-1:0] two;
        default_types();
        @(negedge clk);
        @(negedge clk);
        check("reset_ms", ms, 0);
        check("reset_mf", mf, 0);
        check("reset_first", {first_idx, first_vld}, 0);
        check("reset_busy_done", {busy, done}, 0);
        check("reset_pairs", pair_count, 0);
        rst = 1'b1;
        @(negedge clk);

        // matching pair
        pick(3);
        check("one_first_vld", first_vld, 1);
        check("one_first_idx", first_idx, 3);
        check("one_busy", busy, 0);
        pick(17);
        watch(0, 0, ms_m, mf_m, busy_m);
        check("match_ms_window", ms_m, 8'b0010_0000);
        check("match_mf_window", mf_m, 8'b0000_0000);
        check("match_busy_window", busy_m, 8'b0011_1110);
        check("match_pairs", pair_count, 1);
        check("match_first_vld_after", first_vld, 0);

        // mismatching pair
        do_reset();
        pick(3);
        pick(8);
        watch(0, 0, ms_m, mf_m, busy_m);
        check("miss_ms_window", ms_m, 8'b0000_0000);
        check("miss_mf_window", mf_m, 8'b0010_0000);
        check("miss_pairs", pair_count, 0);

        // same card twice: deselect
        do_reset();
        pick(3);
        pick(3);
        watch(0, 0, ms_m, mf_m, busy_m);
        check("desel_mf_window", mf_m, 8'b0000_0010);
        check("desel_ms_window", ms_m, 8'b0000_0000);
        check("desel_busy_window", busy_m, 8'b0000_0000);
        check("desel_first_vld", first_vld, 0);

        // ignored picks
        do_reset();
        press('0);
        check("zero_cur_state", {first_vld, busy, ms, mf}, 0);
        two = '0;
        two[3] = 1'b1;
        two[8] = 1'b1;
        press(two);
        check("two_hot_idle", {first_vld, busy, ms, mf}, 0);
        hidden_bus[3] = 1'b1;
        pick(3);
        check("hidden_idle", {first_vld, busy, ms, mf}, 0);
        pick(17);
        check("pick17_vld", {first_vld, first_idx}, {1'b1, 6'd17});
        press(two);
        check("two_hot_one", {first_vld, first_idx, busy, ms, mf}, {1'b1, 6'd17, 3'b000});
        pick(3);
        check("hidden_one", {first_vld, first_idx, busy, ms, mf}, {1'b1, 6'd17, 3'b000});
        hidden_bus = '0;

        // edge during HOLD dropped; s held high across return to IDLE
        do_reset();
        pick(3);
        pick(17);
        watch(3, 9, ms_m, mf_m, busy_m);
        s = 1'b0;
        check("hold_drop_ms", ms_m, 8'b0010_0000);
        check("hold_drop_mf", mf_m, 8'b0000_0000);
        check("hold_drop_vld", {first_vld, busy}, 0);
        @(negedge clk);
        check("hold_drop_idle", {first_vld, busy, ms, mf}, 0);

        // reset mid-HOLD
        do_reset();
        pick(3);
        pick(17);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midhold_rst_outs", {ms, mf, first_idx, first_vld, busy, pair_count, done}, 0);
        @(negedge clk);
        rst = 1'b1;
        watch(0, 0, ms_m, mf_m, busy_m);
        check("midhold_no_ms", ms_m, 0);
        check("midhold_no_mf", mf_m, 0);
        check("midhold_pairs", pair_count, 0);

        // full game: 18 matching pairs
        do_reset();
        type_bus = '0;
        for (int i = 0; i < 18; i++) type_bus[(2*i)*TW +: TW] = 4'(i);
        for (int i = 0; i < 18; i++) type_bus[(2*i+1)*TW +: TW] = 4'(i);
        for (int i = 0; i < 18; i++) begin
            pick(2*i);
            pick(2*i+1);
            watch(0, 0, ms_m, mf_m, busy_m);
            check($sformatf("game_ms_%0d", i), {ms_m, mf_m}, {8'b0010_0000, 8'b0});
            hidden_bus[2*i]   = 1'b1;
            hidden_bus[2*i+1] = 1'b1;
        end
        check("game_pairs", pair_count, 18);
        check("game_done", done, 1);
        hidden_bus = '0;
        pick(0);
        pick(1);
        watch(0, 0, ms_m, mf_m, busy_m);
        check("done_ignores", {ms_m, mf_m, busy_m}, 0);
        check("done_hold", {done, first_vld, pair_count}, {2'b10, 5'd18});

        // first-pick timeout
        do_reset();
        default_types();
        pick(3);
        ms_m = '0;
        begin
            logic [31:0] mf_w;
            mf_w = '0;
            for (int j = 1; j <= 30; j++) begin
                mf_w[j] = mf;
                @(negedge clk);
            end
`ifdef MATCH_CTRL_TIMEOUT_EN
            check("timeout_mf", mf_w, 32'h0020_0000);
            check("timeout_vld", first_vld, 0);
`else
            check("no_timeout_mf", mf_w, 0);
            check("no_timeout_vld", first_vld, 1);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
